// File: rtl/axi4_sram_slave.sv
// rtl/axi4_sram_slave.sv - AXI4 single-beat SRAM responder with fixed, programmable response latency
module axi4_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LATENCY  = 2,
  parameter int          WR_LATENCY  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_slave_awvalid,
  output logic        io_slave_awready,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  input  logic        io_slave_wvalid,
  output logic        io_slave_wready,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  output logic        io_slave_bvalid,
  input  logic        io_slave_bready,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  input  logic        io_slave_arvalid,
  output logic        io_slave_arready,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  output logic        io_slave_rvalid,
  input  logic        io_slave_rready,
  output logic [31:0] io_slave_rdata,
  output logic [1:0]  io_slave_rresp,
  output logic [3:0]  io_slave_rid,
  output logic        io_slave_rlast
);

  localparam int          IW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {IDLE, W_DATA, W_WAIT, W_RESP, R_WAIT, R_DATA} state_t;

  state_t         state, state_next;
  logic [7:0]     cnt, cnt_next;
  logic [IW-1:0]  idx_q;
  logic [1:0]     resp_q;
  logic [3:0]     id_q;
  logic [31:0]    rdata_q;
  logic [31:0]    mem [DEPTH_WORDS];
  logic [31:0]    aw_off, ar_off;
  logic [1:0]     aw_resp, ar_resp;
  logic           aw_hs, ar_hs, w_hs;
  logic           unused_ok;

  // DECERR (out of window) outranks SLVERR (burst request)
  function automatic logic [1:0] decode(input logic [31:0] addr, input logic [7:0] len);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    if (addr < ADDR_BASE || {2'b00, off[31:2]} >= DEPTH_L) return 2'b11;
    if (len != 8'd0) return 2'b10;
    return 2'b00;
  endfunction

  assign aw_off  = io_slave_awaddr - ADDR_BASE;
  assign ar_off  = io_slave_araddr - ADDR_BASE;
  assign aw_resp = decode(io_slave_awaddr, io_slave_awlen);
  assign ar_resp = decode(io_slave_araddr, io_slave_arlen);
  assign aw_hs   = io_slave_awvalid && io_slave_awready;
  assign ar_hs   = io_slave_arvalid && io_slave_arready;
  assign w_hs    = io_slave_wvalid && io_slave_wready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    io_slave_awready = 1'b0;
    io_slave_arready = 1'b0;
    io_slave_wready  = 1'b0;
    io_slave_bvalid  = 1'b0;
    io_slave_rvalid  = 1'b0;
    case (state)
      IDLE: begin
        io_slave_awready = !reset;
        io_slave_arready = !reset && !io_slave_awvalid;
        if (aw_hs) begin
          state_next = W_DATA;
        end else if (ar_hs) begin
          state_next = R_WAIT;
          cnt_next   = 8'(RD_LATENCY - 1);
        end
      end
      W_DATA: begin
        io_slave_wready = !reset;
        if (w_hs) begin
          state_next = W_WAIT;
          cnt_next   = 8'(WR_LATENCY - 1);
        end
      end
      W_WAIT, R_WAIT: begin
        if (cnt == 8'd0) state_next = (state == W_WAIT) ? W_RESP : R_DATA;
        else             cnt_next   = cnt - 8'd1;
      end
      W_RESP: begin
        io_slave_bvalid = !reset;
        if (io_slave_bready) state_next = IDLE;
      end
      R_DATA: begin
        io_slave_rvalid = !reset;
        if (io_slave_rready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Array is sampled at the AR handshake so rdata is ready and stable for the whole response
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q   <= '0;
      resp_q  <= 2'b00;
      id_q    <= 4'd0;
      rdata_q <= 32'd0;
    end else if (aw_hs) begin
      idx_q  <= aw_off[IW+1:2];
      resp_q <= aw_resp;
      id_q   <= io_slave_awid;
    end else if (ar_hs) begin
      idx_q   <= ar_off[IW+1:2];
      resp_q  <= ar_resp;
      id_q    <= io_slave_arid;
      rdata_q <= (ar_resp == 2'b00) ? mem[ar_off[IW+1:2]] : 32'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_hs && resp_q == 2'b00) begin
      for (int b = 0; b < 4; b++) begin
        if (io_slave_wstrb[b]) mem[idx_q][8*b +: 8] <= io_slave_wdata[8*b +: 8];
      end
    end
  end

  assign io_slave_bresp = resp_q;
  assign io_slave_bid   = id_q;
  assign io_slave_rresp = resp_q;
  assign io_slave_rid   = id_q;
  assign io_slave_rdata = rdata_q;
  assign io_slave_rlast = io_slave_rvalid;

  assign unused_ok = ^{io_slave_awsize, io_slave_awburst, io_slave_wlast,
                       io_slave_arsize, io_slave_arburst, aw_off, ar_off};

endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb/tb_axi4_sram_slave.sv - randomized self-checking bench for axi4_sram_slave against a word-map model
module tb_axi4_sram_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          RD_L  = 2;
  localparam int          WR_L  = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  awid, wstrb, bid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata;
  logic [3:0]  arid, rid;

  int n_checks = 0;
  int n_fail   = 0;
  bit [31:0] model [int];

  always #5 clock = ~clock;

  axi4_sram_slave #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .RD_LATENCY(RD_L), .WR_LATENCY(WR_L)) dut (
    .clock(clock), .reset(reset),
    .io_slave_awvalid(awvalid), .io_slave_awready(awready), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize), .io_slave_awburst(awburst),
    .io_slave_wvalid(wvalid), .io_slave_wready(wready), .io_slave_wdata(wdata),
    .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bvalid(bvalid), .io_slave_bready(bready), .io_slave_bresp(bresp), .io_slave_bid(bid),
    .io_slave_arvalid(arvalid), .io_slave_arready(arready), .io_slave_araddr(araddr),
    .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize), .io_slave_arburst(arburst),
    .io_slave_rvalid(rvalid), .io_slave_rready(rready), .io_slave_rdata(rdata),
    .io_slave_rresp(rresp), .io_slave_rid(rid), .io_slave_rlast(rlast)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [7:0] len);
    if (addr < BASE) return 2'b11;
    if (((addr - BASE) >> 2) >= DEPTH) return 2'b11;
    if (len != 8'd0) return 2'b10;
    return 2'b00;
  endfunction

  // All tasks start and end on a falling edge
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [3:0] id, input logic [7:0] len, input int hold);
    logic [1:0] er;
    int n, idx;
    er = exp_resp(addr, len);
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = 3'b010;
    wvalid = 1'b1; wdata = data; wstrb = strb; wlast = 1'b1;
    #1;
    check("w_held_off", wready, 1'b0);
    n = 0;
    while (!awready && n < 50) begin @(negedge clock); n++; end
    if (!awready) begin check("aw_timeout", 0, 1); awvalid = 0; wvalid = 0; return; end
    @(negedge clock);
    awvalid = 1'b0;
    n = 0;
    while (!wready && n < 50) begin @(negedge clock); n++; end
    if (!wready) begin check("w_timeout", 0, 1); wvalid = 0; return; end
    @(negedge clock);
    wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clock); n++; end
    check("b_latency", n, WR_L);
    check("bresp", bresp, er);
    check("bid", bid, id);
    repeat (hold) begin
      @(negedge clock);
      check("b_hold_valid", bvalid, 1'b1);
      check("b_hold_bid", bid, id);
      check("b_hold_bresp", bresp, er);
    end
    bready = 1'b1;
    @(negedge clock);
    bready = 1'b0;
    check("b_done", bvalid, 1'b0);
    if (er == 2'b00) begin
      idx = int'((addr - BASE) >> 2);
      if (model.exists(idx) || strb == 4'hF) begin
        bit [31:0] w;
        w = model.exists(idx) ? model[idx] : 32'd0;
        for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
        model[idx] = w;
      end
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len, input int hold);
    logic [1:0]  er;
    logic [31:0] ed;
    bit known;
    int n, idx;
    er = exp_resp(addr, len);
    ed = 32'd0;
    known = 1;
    if (er == 2'b00) begin
      idx = int'((addr - BASE) >> 2);
      if (model.exists(idx)) ed = model[idx];
      else known = 0;
    end
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = 3'b010;
    #1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clock); n++; end
    if (!arready) begin check("ar_timeout", 0, 1); arvalid = 0; return; end
    @(negedge clock);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clock); n++; end
    check("r_latency", n, RD_L);
    check("rlast", rlast, 1'b1);
    check("rid", rid, id);
    check("rresp", rresp, er);
    if (known) check("rdata", rdata, ed);
    repeat (hold) begin
      @(negedge clock);
      check("r_hold_valid", rvalid, 1'b1);
      check("r_hold_rid", rid, id);
      if (known) check("r_hold_rdata", rdata, ed);
    end
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
    check("r_done", rvalid, 1'b0);
  endtask

  initial begin
    reset = 1; awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) @(negedge clock);
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bid", bid, 0);
    check("rst_bresp", bresp, 0);
    reset = 0;
    @(negedge clock);
    check("idle_awready", awready, 1);

    axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 4'd3, 8'd0, 0);
    axi_read(BASE + 32'h10, 4'd4, 8'd0, 0);

    axi_write(BASE + 32'h20, 32'hAABB_CCDD, 4'hF, 4'd1, 8'd0, 0);
    axi_write(BASE + 32'h20, 32'h1122_3344, 4'b0101, 4'd2, 8'd0, 5);
    axi_read(BASE + 32'h20, 4'd6, 8'd0, 5);
    check("strb_merge_model", model[8], 32'hAA22_CC44);

    // Simultaneous AW and AR: write first, read accepted after the write response
    arvalid = 1; araddr = BASE + 32'h20; arid = 4'd9; arlen = 0;
    awvalid = 1;
    #1;
    check("both_awready", awready, 1);
    check("both_arready", arready, 0);
    axi_write(BASE + 32'h24, 32'h0BAD_F00D, 4'hF, 4'd7, 8'd0, 2);
    axi_read(BASE + 32'h20, 4'd9, 8'd0, 0);
    axi_read(BASE + 32'h24, 4'd10, 8'd0, 0);

    axi_read(32'h7FFF_FFFC, 4'd11, 8'd0, 0);
    axi_write(BASE + 32'h10, 32'h1234_5678, 4'hF, 4'd12, 8'd1, 0);
    axi_read(BASE + 32'h10, 4'd13, 8'd0, 0);
    axi_read(BASE + 32'h10, 4'd14, 8'd1, 0);

    // Reset while waiting for read data abandons the response
    arvalid = 1; araddr = BASE + 32'h10; arid = 4'd5; arlen = 0;
    @(negedge clock);
    arvalid = 0;
    check("rwait_rvalid", rvalid, 0);
    reset = 1;
    @(negedge clock);
    check("midrst_rvalid", rvalid, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_awready", awready, 0);
    reset = 0;
    @(negedge clock);
    check("postrst_awready", awready, 1);
    repeat (3) begin
      check("postrst_rvalid", rvalid, 0);
      @(negedge clock);
    end
    axi_read(BASE + 32'h10, 4'd15, 8'd0, 0);

    for (int i = 0; i < 16; i++) axi_write(BASE + 32'(i * 4), $urandom, 4'hF, 4'($urandom), 8'd0, 0);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = $urandom_range(0, 1) ? 32'h7FFF_FFFC : 32'h0000_0100;
      else if (sel == 1) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
      else               a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0,
                  $urandom_range(0, 3));
      else
        axi_read(a, 4'($urandom), ($urandom_range(0, 7) == 0) ? 8'd3 : 8'd0, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
